// File: rtl/multi_cycle_control_if.sv
//==============================================================================
// Module      : multi_cycle_control_if
// Description : Opcode/flag inputs and datapath control outputs of the
//               multi-cycle controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface multi_cycle_control_if;
    logic [5:0] opCode;
    logic       zero;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       ALUM2Reg;
    logic       RegWre;
    logic       RegOut;
    logic       ExtSel;
    logic       DataMemRW;
    logic       halted;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [2:0] state;

    modport master (
        output opCode, zero,
        input  PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUM2Reg, RegWre,
               RegOut, ExtSel, DataMemRW, halted, PCSrc, ALUOp, state
    );

    modport slave (
        input  opCode, zero,
        output PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUM2Reg, RegWre,
               RegOut, ExtSel, DataMemRW, halted, PCSrc, ALUOp, state
    );
endinterface

`default_nettype wire

// File: rtl/multi_cycle_control.sv
//==============================================================================
// Module      : multi_cycle_control
// Description : Multi-cycle CPU control FSM; only state and halt flag are
//               registered, all control outputs are decoded combinationally.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multi_cycle_control (
    input  wire logic             CLK,
    input  wire logic             Reset,
    multi_cycle_control_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_ADDI = 6'b000001;
    localparam logic [5:0] c_OP_SUB  = 6'b000010;
    localparam logic [5:0] c_OP_ORI  = 6'b010000;
    localparam logic [5:0] c_OP_AND  = 6'b010001;
    localparam logic [5:0] c_OP_OR   = 6'b010010;
    localparam logic [5:0] c_OP_SLL  = 6'b011000;
    localparam logic [5:0] c_OP_SLTI = 6'b011011;
    localparam logic [5:0] c_OP_SW   = 6'b100110;
    localparam logic [5:0] c_OP_LW   = 6'b100111;
    localparam logic [5:0] c_OP_BEQ  = 6'b110000;
    localparam logic [5:0] c_OP_BNE  = 6'b110001;
    localparam logic [5:0] c_OP_J    = 6'b111000;
    localparam logic [5:0] c_OP_HALT = 6'b111111;

    state_t state_q, state_d;
    logic   halt_q,  halt_d;

    logic w_add, w_addi, w_sub, w_ori, w_and, w_or, w_sll, w_slti;
    logic w_sw, w_lw, w_beq, w_bne, w_j, w_halt;
    logic w_alu, w_mem, w_br, w_nop, w_dec_en;
    logic [2:0] w_aluop;

    assign w_add  = (bus.opCode == c_OP_ADD);
    assign w_addi = (bus.opCode == c_OP_ADDI);
    assign w_sub  = (bus.opCode == c_OP_SUB);
    assign w_ori  = (bus.opCode == c_OP_ORI);
    assign w_and  = (bus.opCode == c_OP_AND);
    assign w_or   = (bus.opCode == c_OP_OR);
    assign w_sll  = (bus.opCode == c_OP_SLL);
    assign w_slti = (bus.opCode == c_OP_SLTI);
    assign w_sw   = (bus.opCode == c_OP_SW);
    assign w_lw   = (bus.opCode == c_OP_LW);
    assign w_beq  = (bus.opCode == c_OP_BEQ);
    assign w_bne  = (bus.opCode == c_OP_BNE);
    assign w_j    = (bus.opCode == c_OP_J);
    assign w_halt = (bus.opCode == c_OP_HALT);

    assign w_alu = w_add | w_addi | w_sub | w_ori | w_and | w_or | w_sll | w_slti;
    assign w_mem = w_sw | w_lw;
    assign w_br  = w_beq | w_bne;
    assign w_nop = ~(w_alu | w_mem | w_br | w_j | w_halt);

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        case (state_q)
            S_IF:     state_d = halt_q ? S_IF : S_ID;
            S_ID: begin
                if (w_alu)      state_d = S_EXE_AL;
                else if (w_mem) state_d = S_EXE_LS;
                else if (w_br)  state_d = S_EXE_BR;
                else            state_d = S_IF;
                if (w_halt)     halt_d  = 1'b1;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = w_lw ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // Opcode-decoded datapath selects are held at zero during fetch.
    assign w_dec_en = (state_q != S_IF);

    always_comb begin
        w_aluop = 3'b000;
        if (w_sub | w_beq | w_bne) w_aluop = 3'b001;
        else if (w_ori | w_or)     w_aluop = 3'b011;
        else if (w_and)            w_aluop = 3'b100;
        else if (w_sll)            w_aluop = 3'b010;
        else if (w_slti)           w_aluop = 3'b110;
    end

    assign bus.PCWre     = ((state_q == S_ID) & (w_j | w_nop))
                         | (state_q == S_EXE_BR)
                         | ((state_q == S_MEM) & w_sw)
                         | (state_q == S_WB_AL)
                         | (state_q == S_WB_LD);
    // Reset gates the fetch strobes directly so they drop without a clock.
    assign bus.IRWre     = Reset & (state_q == S_IF) & ~halt_q;
    assign bus.InsMemRW  = Reset & (state_q == S_IF) & ~halt_q;
    assign bus.PCSrc     = ((state_q == S_ID) & w_j) ? 2'b10 :
                           ((state_q == S_EXE_BR) &
                            ((w_beq & bus.zero) | (w_bne & ~bus.zero))) ? 2'b01 : 2'b00;
    assign bus.RegWre    = (state_q == S_WB_AL) | (state_q == S_WB_LD);
    assign bus.DataMemRW = (state_q == S_MEM) & w_sw;
    assign bus.ALUM2Reg  = (state_q == S_WB_LD);
    assign bus.ALUSrcA   = w_dec_en & w_sll;
    assign bus.ALUSrcB   = w_dec_en & (w_addi | w_ori | w_slti | w_sw | w_lw);
    assign bus.RegOut    = w_dec_en & ~(w_addi | w_ori | w_slti | w_lw);
    assign bus.ExtSel    = w_dec_en & ~w_ori;
    assign bus.ALUOp     = w_dec_en ? w_aluop : 3'b000;
    assign bus.halted    = halt_q;
    assign bus.state     = state_q;

endmodule

`default_nettype wire
